// File: rtl/ex_mem_pipe_stage.sv
// EX->MEM elastic pipeline register: main + skid entry, valid/ready handshake,
// synchronous flush, bubble-gated control outputs, saturating stall counter.
module ex_mem_pipe_stage #(
  parameter int PC_LENGTH       = 32,
  parameter int DATA_LENGTH     = 32,
  parameter int WBSEL_WIDTH     = 2,
  parameter int RD_WIDTH        = 5,
  parameter int STALL_CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic                       i_flush,
  input  logic [PC_LENGTH-1:0]       i_pc,
  input  logic [DATA_LENGTH-1:0]     i_aluout,
  input  logic [DATA_LENGTH-1:0]     i_rs2_out_fwd,
  input  logic                       i_memRW,
  input  logic                       i_regWEn,
  input  logic [WBSEL_WIDTH-1:0]     i_wbsel,
  input  logic [RD_WIDTH-1:0]        i_rd,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [PC_LENGTH-1:0]       o_pc,
  output logic [DATA_LENGTH-1:0]     o_aluout,
  output logic [DATA_LENGTH-1:0]     o_rs2_out_fwd,
  output logic                       o_memRW,
  output logic                       o_regWEn,
  output logic [WBSEL_WIDTH-1:0]     o_wbsel,
  output logic [RD_WIDTH-1:0]        o_rd,
  output logic [STALL_CNT_WIDTH-1:0] o_stall_cnt
);

  typedef struct packed {
    logic [PC_LENGTH-1:0]   pc;
    logic [DATA_LENGTH-1:0] aluout;
    logic [DATA_LENGTH-1:0] rs2;
    logic                   memrw;
    logic                   regwen;
    logic [WBSEL_WIDTH-1:0] wbsel;
    logic [RD_WIDTH-1:0]    rd;
  } payload_t;

  localparam logic [STALL_CNT_WIDTH-1:0] CNT_ONE = {{(STALL_CNT_WIDTH-1){1'b0}}, 1'b1};

  payload_t in_pl;
  payload_t main_q, main_d, skid_q, skid_d;
  logic     main_valid_q, main_valid_d;
  logic     skid_valid_q, skid_valid_d;
  logic [STALL_CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic     accept, drain;

  // Pack the incoming payload fields.
  always_comb begin
    in_pl        = '0;
    in_pl.pc     = i_pc;
    in_pl.aluout = i_aluout;
    in_pl.rs2    = i_rs2_out_fwd;
    in_pl.memrw  = i_memRW;
    in_pl.regwen = i_regWEn;
    in_pl.wbsel  = i_wbsel;
    in_pl.rd     = i_rd;
  end

  // Ready comes only from the skid flag, so there is no path from i_ready.
  assign o_ready = ~skid_valid_q;
  assign accept  = i_valid & ~skid_valid_q;
  assign drain   = main_valid_q & i_ready;

  // Next-state for main/skid entries; flush overrides accept and drain.
  always_comb begin
    main_d       = main_q;
    main_valid_d = main_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (i_flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      // Skid full: nothing can be accepted; refill main from skid on drain.
      if (drain) begin
        main_d       = skid_q;
        skid_valid_d = 1'b0;
      end
    end else if (!main_valid_q || drain) begin
      if (accept) begin
        main_d       = in_pl;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      // Main held by backpressure: park the new payload in skid.
      skid_d       = in_pl;
      skid_valid_d = 1'b1;
    end
  end

  // Count backpressured cycles, saturating at all-ones.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (main_valid_q && !i_ready && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + CNT_ONE;
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      stall_cnt_q  <= '0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign o_valid       = main_valid_q;
  assign o_pc          = main_q.pc;
  assign o_aluout      = main_q.aluout;
  assign o_rs2_out_fwd = main_q.rs2;
  assign o_wbsel       = main_q.wbsel;
  assign o_rd          = main_q.rd;
  // Stale payload in an empty stage must never write memory or the regfile.
  assign o_memRW       = main_q.memrw  & main_valid_q;
  assign o_regWEn      = main_q.regwen & main_valid_q;
  assign o_stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_ex_mem_pipe_stage.sv
// Scoreboard bench for ex_mem_pipe_stage: a FIFO-occupancy reference model
// tracks accepted payloads; a negedge monitor compares every DUT output.
module tb_ex_mem_pipe_stage;
  localparam int PW = 32, DW = 32, WW = 2, RW = 5, CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;
  logic i_valid, o_ready, i_flush, i_memRW, i_regWEn, o_valid, i_ready;
  logic [PW-1:0] i_pc, o_pc;
  logic [DW-1:0] i_aluout, i_rs2_out_fwd, o_aluout, o_rs2_out_fwd;
  logic [WW-1:0] i_wbsel, o_wbsel;
  logic [RW-1:0] i_rd, o_rd;
  logic o_memRW, o_regWEn;
  logic [CW-1:0] o_stall_cnt;

  ex_mem_pipe_stage #(.PC_LENGTH(PW), .DATA_LENGTH(DW), .WBSEL_WIDTH(WW),
                      .RD_WIDTH(RW), .STALL_CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready), .i_flush(i_flush),
    .i_pc(i_pc), .i_aluout(i_aluout), .i_rs2_out_fwd(i_rs2_out_fwd),
    .i_memRW(i_memRW), .i_regWEn(i_regWEn), .i_wbsel(i_wbsel), .i_rd(i_rd),
    .o_valid(o_valid), .i_ready(i_ready), .o_pc(o_pc), .o_aluout(o_aluout),
    .o_rs2_out_fwd(o_rs2_out_fwd), .o_memRW(o_memRW), .o_regWEn(o_regWEn),
    .o_wbsel(o_wbsel), .o_rd(o_rd), .o_stall_cnt(o_stall_cnt));

  always #5 clk = ~clk;

  typedef struct {
    logic [PW-1:0] pc;
    logic [DW-1:0] alu;
    logic [DW-1:0] rs2;
    logic          mw;
    logic          rw;
    logic [WW-1:0] wb;
    logic [RW-1:0] rd;
  } pl_t;

  pl_t q[$];        // payloads held by the stage, oldest first
  int  scnt = 0;    // expected stall count
  int  nvec = 0;
  int  nerr = 0;
  bit  mon_en = 0;
  logic [DW-1:0] last_alu;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare outputs with the model, then advance the model for the next edge.
  always @(negedge clk) begin : mon
    pl_t e;
    pl_t n;
    bit  acc;
    if (mon_en && !rst) begin
      chk("o_valid", 64'(o_valid), 64'(q.size() > 0));
      chk("o_ready", 64'(o_ready), 64'(q.size() < 2));
      chk("o_stall_cnt", 64'(o_stall_cnt), 64'(scnt));
      if (q.size() > 0) begin
        e = q[0];
        chk("o_pc", 64'(o_pc), 64'(e.pc));
        chk("o_aluout", 64'(o_aluout), 64'(e.alu));
        chk("o_rs2_out_fwd", 64'(o_rs2_out_fwd), 64'(e.rs2));
        chk("o_wbsel", 64'(o_wbsel), 64'(e.wb));
        chk("o_rd", 64'(o_rd), 64'(e.rd));
        chk("o_memRW", 64'(o_memRW), 64'(e.mw));
        chk("o_regWEn", 64'(o_regWEn), 64'(e.rw));
      end else begin
        chk("o_memRW_bubble", 64'(o_memRW), 64'(0));
        chk("o_regWEn_bubble", 64'(o_regWEn), 64'(0));
      end
      if (q.size() > 0 && !i_ready) scnt = (scnt >= CMAX) ? CMAX : scnt + 1;
      acc = i_valid && (q.size() < 2);
      if (i_flush) q.delete();
      else begin
        if (q.size() > 0 && i_ready) void'(q.pop_front());
        if (acc) begin
          n.pc = i_pc; n.alu = i_aluout; n.rs2 = i_rs2_out_fwd; n.mw = i_memRW;
          n.rw = i_regWEn; n.wb = i_wbsel; n.rd = i_rd;
          q.push_back(n);
        end
      end
    end
  end

  task automatic drive(input bit v, input logic [PW-1:0] pc, input bit rdy,
                       input bit fl, input bit mw, input bit rw);
    @(posedge clk); #1;
    i_valid = v; i_pc = pc; i_aluout = $urandom; i_rs2_out_fwd = $urandom;
    i_memRW = mw; i_regWEn = rw; i_wbsel = WW'($urandom); i_rd = RW'($urandom);
    i_ready = rdy; i_flush = fl;
  endtask

  task automatic idle_inputs();
    i_valid = 0; i_flush = 0; i_ready = 1; i_memRW = 0; i_regWEn = 0;
    i_pc = '0; i_aluout = '0; i_rs2_out_fwd = '0; i_wbsel = '0; i_rd = '0;
  endtask

  // Asynchronous reset pulse between edges, checking outputs clear immediately.
  task automatic do_reset(input string tag);
    @(posedge clk); #3;
    rst = 1;
    #1;
    chk({tag, "_rst_valid"}, 64'(o_valid), 64'(0));
    chk({tag, "_rst_memRW"}, 64'(o_memRW), 64'(0));
    chk({tag, "_rst_regWEn"}, 64'(o_regWEn), 64'(0));
    chk({tag, "_rst_cnt"}, 64'(o_stall_cnt), 64'(0));
    chk({tag, "_rst_pc"}, 64'(o_pc), 64'(0));
    q.delete(); scnt = 0;
    idle_inputs();
    @(posedge clk); #3;
    rst = 0;
    #1;
    chk({tag, "_rst_ready"}, 64'(o_ready), 64'(1));
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    #1;
    chk("init_valid", 64'(o_valid), 64'(0));
    chk("init_cnt", 64'(o_stall_cnt), 64'(0));
    #12 rst = 0;
    #1 chk("init_ready", 64'(o_ready), 64'(1));
    mon_en = 1;

    // Full throughput.
    for (int k = 0; k < 4; k++) drive(1, PW'(4 * k), 1, 0, k[0], k[1]);
    drive(0, 0, 1, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0);
    chk("t2_cnt", 64'(o_stall_cnt), 64'(0));

    // Reset mid-stream with backpressure so the counter is nonzero.
    drive(1, 32'h100, 0, 0, 1, 1);
    drive(1, 32'h104, 0, 0, 1, 1);
    drive(1, 32'h108, 0, 0, 1, 1);
    do_reset("t1");

    // Backpressure into skid, upstream holds 0x18 until accepted.
    drive(1, 32'h10, 0, 0, 0, 1);
    drive(1, 32'h14, 0, 0, 1, 0);
    drive(1, 32'h18, 0, 0, 0, 0);
    drive(1, 32'h18, 0, 0, 0, 0);
    drive(1, 32'h18, 1, 0, 0, 0);
    drive(1, 32'h18, 1, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0);
    chk("t3_cnt", 64'(o_stall_cnt), 64'(3));

    // Flush with full skid drops 0x20, 0x24 and the concurrent 0x28.
    drive(1, 32'h20, 0, 0, 1, 1);
    drive(1, 32'h24, 0, 0, 1, 1);
    drive(1, 32'h28, 0, 1, 1, 1);
    drive(0, 0, 1, 0, 0, 0);
    chk("t4_valid", 64'(o_valid), 64'(0));
    chk("t4_ready", 64'(o_ready), 64'(1));
    chk("t4_memRW", 64'(o_memRW), 64'(0));
    drive(0, 0, 1, 0, 0, 0);

    // Bubble gating: control outputs drop with valid, payload is retained.
    drive(1, 32'h30, 1, 0, 1, 1);
    last_alu = i_aluout;
    drive(0, 0, 1, 0, 0, 0);
    chk("t5_memRW_on", 64'(o_memRW), 64'(1));
    drive(0, 0, 1, 0, 0, 0);
    chk("t5_memRW_off", 64'(o_memRW), 64'(0));
    chk("t5_regWEn_off", 64'(o_regWEn), 64'(0));
    chk("t5_alu_hold", 64'(o_aluout), 64'(last_alu));

    // Counter saturation.
    do_reset("t6");
    drive(1, 32'h40, 0, 0, 0, 0);
    for (int k = 0; k < 20; k++) drive(0, 0, 0, 0, 0, 0);
    chk("t6_cnt_sat", 64'(o_stall_cnt), 64'(CMAX));
    drive(0, 0, 1, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0);

    // Randomised traffic, backpressure and flushes.
    do_reset("rnd");
    for (int k = 0; k < 1500; k++)
      drive(1'($urandom_range(0, 2) != 0), $urandom, 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 15) == 0), 1'($urandom), 1'($urandom));
    drive(0, 0, 1, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0);
    @(posedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
